// File: rtl/countdown_pkg.sv
// rtl/countdown_pkg.sv - shared types and default constants for the countdown bank
//
// Purpose : channel state encoding, default sizing and the chSel width helper.
// Ports   : none (package).

package countdown_pkg;

  localparam int unsigned DEFAULT_WIDTH  = 32;
  localparam int unsigned DEFAULT_NUM_CH = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } ch_state_e;

  // Channel-select width; a single-channel bank still gets a 1-bit select.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/countdown_channel.sv
// rtl/countdown_channel.sv - one countdown channel with reload and sticky done
//
// Purpose : IDLE/RUN/EXPIRED countdown with optional auto-reload.
// Ports   : clk_i, rst_ni          clock, async active-low reset
//           tick_i                 shared count-enable strobe
//           load_i, load_value_i   write reload register and counter (decoded by the bank)
//           start_i, reload_i      run level, auto-reload mode
//           clear_done_i           sticky-done clear
//           count_o, done_o        live counter, sticky expiry flag
//           expire_o               one-cycle expiry pulse

module countdown_channel
  import countdown_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             tick_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_value_i,
  input  logic             start_i,
  input  logic             reload_i,
  input  logic             clear_done_i,
  output logic [WIDTH-1:0] count_o,
  output logic             done_o,
  output logic             expire_o
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  ch_state_e        state_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] reload_q;
  logic             done_q;
  logic             expire_q;

  logic             expiring;

  // The 1->0 step; a load on the same edge takes priority and suppresses it.
  assign expiring = !load_i && (state_q == RUN) && start_i && tick_i && (count_q == ONE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
      expire_q <= 1'b0;
    end else begin
      expire_q <= expiring;

      // A fresh expiry beats a simultaneous clear.
      if (expiring) begin
        done_q <= 1'b1;
      end else if (load_i || clear_done_i) begin
        done_q <= 1'b0;
      end

      if (load_i) begin
        reload_q <= load_value_i;
        count_q  <= load_value_i;
        state_q  <= IDLE;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (start_i && (count_q != '0)) begin
              state_q <= RUN;
            end
          end
          RUN: begin
            if (!start_i) begin
              state_q <= IDLE;
            end else if (tick_i) begin
              if (count_q == ONE) begin
                // Reload directly from 1 so that 0 is never visible.
                if (reload_i && (reload_q != '0)) begin
                  count_q <= reload_q;
                end else begin
                  count_q <= '0;
                  state_q <= EXPIRED;
                end
              end else if (count_q != '0) begin
                count_q <= count_q - ONE;
              end
            end
          end
          EXPIRED: begin
            state_q <= EXPIRED;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign count_o  = count_q;
  assign done_o   = done_q;
  assign expire_o = expire_q;

endmodule

// File: rtl/countdown_bank.sv
// rtl/countdown_bank.sv - bank of independent countdown channels with shared load port
//
// Purpose : decodes the shared load port onto NUM_CH countdown_channel instances and,
//           when COUNTDOWN_BANK_IRQ_EN is defined, produces a registered masked interrupt.
// Ports   : CLK, resetN               clock, async active-low reset
//           tick                      shared count-enable strobe
//           chSel, initialValue, load load port (out-of-range chSel ignored)
//           start, reload, clearDone  per-channel run level, reload mode, done clear
//           count                     channel i at [i*WIDTH +: WIDTH]
//           done, expire              sticky flag, one-cycle pulse per channel
//           irqMask, irq              only with COUNTDOWN_BANK_IRQ_EN

module countdown_bank
  import countdown_pkg::*;
#(
  parameter  int unsigned WIDTH  = DEFAULT_WIDTH,
  parameter  int unsigned NUM_CH = DEFAULT_NUM_CH,
  localparam int unsigned SEL_W  = sel_width(NUM_CH)
) (
  input  logic                    CLK,
  input  logic                    resetN,
  input  logic                    tick,
  input  logic [SEL_W-1:0]        chSel,
  input  logic [WIDTH-1:0]        initialValue,
  input  logic                    load,
  input  logic [NUM_CH-1:0]       start,
  input  logic [NUM_CH-1:0]       reload,
  input  logic [NUM_CH-1:0]       clearDone,
`ifdef COUNTDOWN_BANK_IRQ_EN
  input  logic [NUM_CH-1:0]       irqMask,
  output logic                    irq,
`endif
  output logic [NUM_CH*WIDTH-1:0] count,
  output logic [NUM_CH-1:0]       done,
  output logic [NUM_CH-1:0]       expire
);

  logic [NUM_CH-1:0] load_hit;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // Selects at or above NUM_CH match no channel and are dropped.
    assign load_hit[i] = load && (chSel == SEL_W'(i));

    countdown_channel #(
      .WIDTH (WIDTH)
    ) u_channel (
      .clk_i        (CLK),
      .rst_ni       (resetN),
      .tick_i       (tick),
      .load_i       (load_hit[i]),
      .load_value_i (initialValue),
      .start_i      (start[i]),
      .reload_i     (reload[i]),
      .clear_done_i (clearDone[i]),
      .count_o      (count[i*WIDTH +: WIDTH]),
      .done_o       (done[i]),
      .expire_o     (expire[i])
    );
  end

`ifdef COUNTDOWN_BANK_IRQ_EN
  logic irq_q;

  always_ff @(posedge CLK or negedge resetN) begin
    if (!resetN) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= |(done & irqMask);
    end
  end

  assign irq = irq_q;
`endif

endmodule
